// File: rtl/operand_entry_if.sv
// Keypad / operand bundle for operand_entry.
//   row         keypad row sense, active-low, asynchronous to clk
//   col         keypad column drive, active-low one-cold
//   number0/1   the two decimal operands, 0..99
//   operand_sel operand that digits are entered into (0 = number0)
//   key_valid   one-cycle pulse for every accepted key
//   key_code    last accepted key: 0-9 digits, 10 = '*', 11 = '#'
// slave is the operand_entry side; master is the keypad/host side.
interface operand_entry_if;
    logic [3:0] row;
    logic [2:0] col;
    logic [6:0] number0;
    logic [6:0] number1;
    logic       operand_sel;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        output row,
        input  col, number0, number1, operand_sel, key_valid, key_code
    );

    modport slave (
        input  row,
        output col, number0, number1, operand_sel, key_valid, key_code
    );
endinterface

// File: rtl/operand_entry.sv
// Scans a 4x3 matrix keypad, debounces one key at a time and builds two
// two-digit decimal operands from the accepted keys.
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   kp     operand_entry_if.slave: row in; col, number0, number1,
//          operand_sel, key_valid, key_code out (all registered)
// SCAN_DIV: cycles each column is driven (>= 4).
// DEBOUNCE: consecutive frames needed to accept a press or a release (>= 1).
module operand_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_entry_if.slave kp
);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} key_state_e;

    localparam int              CW        = $clog2(SCAN_DIV);
    localparam int              DW        = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]   DEB_LAST  = DW'(DEBOUNCE);
    localparam logic [DW-1:0]   DEB_ONE   = DW'(1);

    // Row 0..2 hold the digits 1..9; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        if (r == 2'd3) begin
            case (c)
                2'd0:    key_map = 4'd10;
                2'd1:    key_map = 4'd0;
                default: key_map = 4'd11;
            endcase
        end else begin
            key_map = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
        end
    endfunction

    logic [3:0]    row_meta, row_sync;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    col_idx;
    logic [2:0]    col_q;
    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic [2:0]    col_hits, tot_hits;
    logic [3:0]    col_code, frame_code;
    logic          sample, frame_end, frame_empty, frame_single;
    key_state_e    state_q, state_d;
    logic [DW-1:0] stable_q, stable_d, rel_q, rel_d;
    logic [3:0]    cand_q, cand_d;
    logic          accept;
    logic [6:0]    number0_q, number1_q, active, shifted;
    logic          sel_q, key_valid_q;
    logic [3:0]    key_code_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
        end
    end

    assign sample    = (scan_cnt == SCAN_LAST);
    assign frame_end = sample && (col_idx == 2'd2);

    // Column drive rotates left: 110 -> 101 -> 011 -> 110.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            col_idx  <= 2'd0;
            col_q    <= 3'b110;
        end else if (sample) begin
            scan_cnt <= '0;
            col_idx  <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
            col_q    <= {col_q[1:0], col_q[2]};
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    // NOTE: every variable written in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        col_hits = 3'd0;
        col_code = 4'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = key_map(2'(r), col_idx);
            end
        end
    end

    // Frame result = closures gathered in earlier columns plus this column.
    assign tot_hits     = {1'b0, acc_hits} + col_hits;
    assign frame_code   = (acc_hits == 2'd1) ? acc_code : col_code;
    assign frame_empty  = (tot_hits == 3'd0);
    assign frame_single = (tot_hits == 3'd1);

    // acc_hits saturates at 2: only none / one / several matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (frame_end) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (sample) begin
            acc_hits <= (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
            acc_code <= frame_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stable_q <= '0;
            rel_q    <= '0;
            cand_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            rel_q    <= rel_d;
            cand_q   <= cand_d;
        end
    end

    // Key FSM advances only at frame end. A multi-key frame never starts or
    // continues a press but does count as "still held" for release.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        rel_d    = rel_q;
        cand_d   = cand_q;
        accept   = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_single) begin
                        cand_d = frame_code;
                        if (DEB_LAST == DEB_ONE) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            stable_d = DEB_ONE;
                            state_d  = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (frame_single && frame_code == cand_q) begin
                        if (stable_q + DEB_ONE == DEB_LAST) begin
                            accept   = 1'b1;
                            stable_d = '0;
                            state_d  = HELD;
                        end else begin
                            stable_d = stable_q + DEB_ONE;
                        end
                    end else if (frame_single) begin
                        cand_d   = frame_code;
                        stable_d = DEB_ONE;
                    end else begin
                        stable_d = '0;
                        state_d  = IDLE;
                    end
                end
                HELD: begin
                    if (frame_empty) begin
                        if (DEB_LAST == DEB_ONE) begin
                            state_d = IDLE;
                        end else begin
                            rel_d   = DEB_ONE;
                            state_d = RELEASE;
                        end
                    end
                end
                default: begin
                    if (!frame_empty) begin
                        rel_d   = '0;
                        state_d = HELD;
                    end else if (rel_q + DEB_ONE == DEB_LAST) begin
                        rel_d   = '0;
                        state_d = IDLE;
                    end else begin
                        rel_d = rel_q + DEB_ONE;
                    end
                end
            endcase
        end
    end

    // Keeping only the last digit before shifting bounds the result to 99.
    assign active  = sel_q ? number1_q : number0_q;
    assign shifted = (active % 7'd10) * 7'd10 + {3'b000, frame_code};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number0_q   <= 7'd0;
            number1_q   <= 7'd0;
            sel_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= frame_code;
                case (frame_code)
                    4'd10: begin
                        if (sel_q) number1_q <= 7'd0;
                        else       number0_q <= 7'd0;
                    end
                    4'd11: sel_q <= ~sel_q;
                    default: begin
                        if (sel_q) number1_q <= shifted;
                        else       number0_q <= shifted;
                    end
                endcase
            end
        end
    end

    assign kp.col         = col_q;
    assign kp.number0     = number0_q;
    assign kp.number1     = number1_q;
    assign kp.operand_sel = sel_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_code    = key_code_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with SCAN_DIV = 4, DEBOUNCE = 2
// (one frame = 12 clocks). A keypad model turns the set of closed keys and
// the driven column into row levels. Key changes are made 1 ns after a
// frame boundary edge so each change covers whole frames.
module tb_operand_entry;

    localparam int FRAME = 12;

    logic clk;
    logic rst_n;
    logic [3:0][2:0] keys;       // keys[row][col] = 1 when closed
    logic [3:0] row_v;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    logic [3:0] codes[$];

    operand_entry_if kif();

    operand_entry #(
        .SCAN_DIV(4),
        .DEBOUNCE(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_v = 4'hF;
        for (int r = 0; r < 4; r++) row_v[r] = ~|(keys[r] & ~kif.col);
    end
    assign kif.row = row_v;

    // Every high cycle of key_valid is counted, so a stretched pulse shows.
    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            pulses = pulses + 1;
            codes.push_back(kif.key_code);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int code_at(input int i);
        if (i < codes.size()) return int'(codes[i]);
        return 99;
    endfunction

    task automatic set_key(input int code, input bit on);
        int r, c;
        if (code == 0)       begin r = 3; c = 1; end
        else if (code == 10) begin r = 3; c = 0; end
        else if (code == 11) begin r = 3; c = 2; end
        else                 begin r = (code - 1) / 3; c = (code - 1) % 3; end
        keys[r][c] = on;
    endtask

    task automatic wait_frames(input int n);
        repeat (FRAME * n) @(posedge clk);
        #1;
    endtask

    task automatic tap(input int code, input int on_frames, input int off_frames);
        set_key(code, 1'b1);
        wait_frames(on_frames);
        set_key(code, 1'b0);
        wait_frames(off_frames);
    endtask

    // Edges from now until key_valid is seen, bounded.
    task automatic edges_to_pulse(output int n);
        n = 0;
        while (n < 4 * FRAME) begin
            @(posedge clk);
            n++;
            #1;
            if (kif.key_valid === 1'b1) break;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col"},  32'(kif.col), 32'b110);
        check({tag, "_n0"},   32'(kif.number0), 0);
        check({tag, "_n1"},   32'(kif.number1), 0);
        check({tag, "_sel"},  32'(kif.operand_sel), 0);
        check({tag, "_kv"},   32'(kif.key_valid), 0);
        check({tag, "_code"}, 32'(kif.key_code), 0);
    endtask

    initial begin
        int p0, n;
        keys  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;
        wait_frames(1);

        // '4' then '2' into number0
        p0 = pulses;
        tap(4, 4, 3);
        tap(2, 4, 3);
        check("42_pulses", 32'(pulses - p0), 2);
        check("42_code0", 32'(code_at(p0)), 4);
        check("42_code1", 32'(code_at(p0 + 1)), 2);
        check("42_n0", 32'(kif.number0), 42);
        check("42_n1", 32'(kif.number1), 0);
        check("42_sel", 32'(kif.operand_sel), 0);

        // '7' keeps the last digit: 42 -> 27
        tap(7, 4, 3);
        check("27_n0", 32'(kif.number0), 27);
        check("27_code", 32'(kif.key_code), 7);

        // '#' switches operand, '9' goes to number1
        tap(11, 4, 3);
        check("hash_sel", 32'(kif.operand_sel), 1);
        check("hash_code", 32'(kif.key_code), 11);
        tap(9, 4, 3);
        check("n1_9", 32'(kif.number1), 9);
        check("n0_kept", 32'(kif.number0), 27);

        // '*' clears only the active operand
        tap(10, 4, 3);
        check("star_n1", 32'(kif.number1), 0);
        check("star_n0", 32'(kif.number0), 27);
        check("star_sel", 32'(kif.operand_sel), 1);

        // '5' closed for a single frame is a bounce
        p0 = pulses;
        tap(5, 1, 5);
        check("bounce_pulses", 32'(pulses - p0), 0);
        check("bounce_n0", 32'(kif.number0), 27);
        check("bounce_n1", 32'(kif.number1), 0);

        // '8' held 20 frames, '3' added partway: one accept, no rollover
        p0 = pulses;
        set_key(8, 1'b1);
        edges_to_pulse(n);
        check("hold8_latency", 32'(n), 2 * FRAME);
        wait_frames(8);
        set_key(3, 1'b1);
        wait_frames(10);
        set_key(3, 1'b0);
        set_key(8, 1'b0);
        wait_frames(3);
        check("hold8_pulses", 32'(pulses - p0), 1);
        check("hold8_code", 32'(code_at(p0)), 8);
        check("hold8_n1", 32'(kif.number1), 8);

        // '1'+'6' together are ignored; '6' alone is then accepted
        p0 = pulses;
        set_key(1, 1'b1);
        set_key(6, 1'b1);
        wait_frames(5);
        check("multi_pulses", 32'(pulses - p0), 0);
        set_key(1, 1'b0);
        wait_frames(2);
        set_key(6, 1'b0);
        wait_frames(3);
        check("six_pulses", 32'(pulses - p0), 1);
        check("six_code", 32'(code_at(p0)), 6);
        check("six_n1", 32'(kif.number1), 86);

        // Reset while '9' is being debounced; '9' stays held through reset
        set_key(9, 1'b1);
        wait_frames(1);
        #20;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        p0 = pulses;
        @(negedge clk) rst_n = 1'b1;
        edges_to_pulse(n);
        check("rst9_latency", 32'(n), 2 * FRAME);
        #1;
        check("rst9_n0", 32'(kif.number0), 9);
        check("rst9_code", 32'(kif.key_code), 9);
        set_key(9, 1'b0);
        wait_frames(3);
        check("rst9_pulses", 32'(pulses - p0), 1);
        check("rst9_n1", 32'(kif.number1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
